store_buffer_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the data memory, between the pipeline MEM stage and the data memory's write and read ports.
- Holds committed stores in an in-order FIFO and drains one store per cycle into the memory write port.
- Services loads through the memory read port, forwarding from pending stores when the youngest overlapping store fully covers the load.
- Stalls the load when pending stores only partially cover it.

---
 rtl/store_buffer_lsu.sv | 158 +++++++++++++++
 tb/tb_store_buffer_lsu.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_lsu.sv
// store_buffer_lsu: in-order store buffer between the MEM stage and the data memory.
// Committed stores queue here and drain one per cycle to the memory write port.
// Loads read memory combinationally. A load is served from a pending store when the
// youngest overlapping store fully covers it, and it stalls on partial coverage.
module store_buffer_lsu #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset_n,
    input  logic             LSU_store_valid,
    output logic             LSU_store_ready,
    input  logic [1:0]       LSU_store_length,
    input  logic [31:0]      LSU_store_address,
    input  logic [31:0]      LSU_store_data,
    input  logic             LSU_load_valid,
    input  logic [1:0]       LSU_load_length,
    input  logic             LSU_load_signed,
    input  logic [31:0]      LSU_load_address,
    output logic [31:0]      LSU_load_data,
    output logic             LSU_load_stall,
    input  logic             SB_drain_hold,
    output logic [PTR_W:0]   SB_count,
    output logic             SB_empty,
    output logic [1:0]       MEM_write_length,
    output logic [31:0]      MEM_write_address,
    output logic [31:0]      MEM_write_data,
    output logic [1:0]       MEM_read_length,
    output logic             MEM_read_signed,
    output logic [31:0]      MEM_read_address,
    input  logic [31:0]      MEM_read_data
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    // Size code to byte count; code 00 means no access.
    function automatic logic [2:0] size_bytes(input logic [1:0] len);
        case (len)
            2'b01:   size_bytes = 3'd1;
            2'b10:   size_bytes = 3'd2;
            2'b11:   size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    logic [1:0]       len_q  [DEPTH];
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             enq, drain, load_act, hit, fwd_ok;
    logic [PTR_W-1:0] hit_idx;
    logic [DEPTH-1:0] ovl;
    logic [32:0]      l_end;
    logic [31:0]      fwd_raw, fwd_ext;

    assign LSU_store_ready = (count_q < FULL);
    assign enq             = LSU_store_valid && LSU_store_ready && (LSU_store_length != 2'b00);
    assign drain           = (count_q != '0) && !SB_drain_hold;
    assign SB_count        = count_q;
    assign SB_empty        = (count_q == '0);

    assign MEM_write_length  = drain ? len_q[head_q] : 2'b00;
    assign MEM_write_address = addr_q[head_q];
    assign MEM_write_data    = data_q[head_q];

    assign MEM_read_address = LSU_load_address;
    assign MEM_read_length  = LSU_load_length;
    assign MEM_read_signed  = LSU_load_signed;

    // Pointer, count and valid-bit next state. A drain clears its slot before an enqueue sets one.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset drops every pending store.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload; only meaningful while its valid bit is set.
    always_ff @(posedge SYS_clk) begin
        if (enq) begin
            len_q[tail_q]  <= LSU_store_length;
            addr_q[tail_q] <= LSU_store_address;
            data_q[tail_q] <= LSU_store_data;
        end
    end

    // Per-entry byte-range overlap with the load. Ends are 33 bits, so ranges near the top do not wrap.
    always_comb begin
        load_act = LSU_load_valid && (LSU_load_length != 2'b00);
        l_end    = {1'b0, LSU_load_address} + 33'(size_bytes(LSU_load_length));
        ovl      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            ovl[k] = load_act && valid_q[k] &&
                     ({1'b0, addr_q[k]} < l_end) &&
                     ({1'b0, LSU_load_address} < ({1'b0, addr_q[k]} + 33'(size_bytes(len_q[k]))));
        end
    end

    // Youngest overlapping entry: walk back from tail-1. When full, the last step wraps to the oldest entry.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            if (!hit && ovl[tail_q - PTR_W'(i)]) begin
                hit     = 1'b1;
                hit_idx = tail_q - PTR_W'(i);
            end
        end
    end

    // Forward on exact start match with full coverage; anything else that overlaps stalls.
    always_comb begin
        fwd_raw = data_q[hit_idx];
        fwd_ok  = hit && (addr_q[hit_idx] == LSU_load_address) &&
                  (size_bytes(len_q[hit_idx]) >= size_bytes(LSU_load_length));
        case (LSU_load_length)
            2'b01:   fwd_ext = {{24{LSU_load_signed & fwd_raw[7]}},  fwd_raw[7:0]};
            2'b10:   fwd_ext = {{16{LSU_load_signed & fwd_raw[15]}}, fwd_raw[15:0]};
            default: fwd_ext = fwd_raw;
        endcase
        LSU_load_stall = load_act && hit && !fwd_ok;
        if (!load_act || !hit) LSU_load_data = MEM_read_data;
        else if (fwd_ok)       LSU_load_data = fwd_ext;
        else                   LSU_load_data = '0;
    end

endmodule

// File: tb/tb_store_buffer_lsu.sv
// Self-checking bench for store_buffer_lsu. Accepted stores push an expected memory
// write onto a queue. A monitor pops that queue whenever the DUT presents a write.
// Load results are checked inline against constants and a simple memory model.
module tb_store_buffer_lsu;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic             SYS_clk = 1'b0;
    logic             SYS_reset_n;
    logic             LSU_store_valid;
    logic             LSU_store_ready;
    logic [1:0]       LSU_store_length;
    logic [31:0]      LSU_store_address;
    logic [31:0]      LSU_store_data;
    logic             LSU_load_valid;
    logic [1:0]       LSU_load_length;
    logic             LSU_load_signed;
    logic [31:0]      LSU_load_address;
    logic [31:0]      LSU_load_data;
    logic             LSU_load_stall;
    logic             SB_drain_hold;
    logic [PTR_W:0]   SB_count;
    logic             SB_empty;
    logic [1:0]       MEM_write_length;
    logic [31:0]      MEM_write_address;
    logic [31:0]      MEM_write_data;
    logic [1:0]       MEM_read_length;
    logic             MEM_read_signed;
    logic [31:0]      MEM_read_address;
    logic [31:0]      MEM_read_data;

    typedef struct packed {
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    store_buffer_lsu #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n),
        .LSU_store_valid(LSU_store_valid), .LSU_store_ready(LSU_store_ready),
        .LSU_store_length(LSU_store_length), .LSU_store_address(LSU_store_address),
        .LSU_store_data(LSU_store_data),
        .LSU_load_valid(LSU_load_valid), .LSU_load_length(LSU_load_length),
        .LSU_load_signed(LSU_load_signed), .LSU_load_address(LSU_load_address),
        .LSU_load_data(LSU_load_data), .LSU_load_stall(LSU_load_stall),
        .SB_drain_hold(SB_drain_hold), .SB_count(SB_count), .SB_empty(SB_empty),
        .MEM_write_length(MEM_write_length), .MEM_write_address(MEM_write_address),
        .MEM_write_data(MEM_write_data),
        .MEM_read_length(MEM_read_length), .MEM_read_signed(MEM_read_signed),
        .MEM_read_address(MEM_read_address), .MEM_read_data(MEM_read_data)
    );

    always #5 SYS_clk = ~SYS_clk;

    // Memory model: read data is a fixed function of the address.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        mem_rd = {a[15:0], 16'hC3A5};
    endfunction
    assign MEM_read_data = mem_rd(MEM_read_address);

    // Write monitor: any presented write is captured at the next edge, so it must match the queue head.
    always @(negedge SYS_clk) begin : wr_mon
        wr_t e;
        if (SYS_reset_n && MEM_write_length != 2'b00) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL mem_write_unexpected: got len=%0d addr=%h data=%h, required no write",
                         MEM_write_length, MEM_write_address, MEM_write_data);
            end else begin
                e = exp_q.pop_front();
                if ({MEM_write_length, MEM_write_address, MEM_write_data} !== e) begin
                    bad++;
                    $display("FAIL mem_write_order: got len=%0d addr=%h data=%h, required len=%0d addr=%h data=%h",
                             MEM_write_length, MEM_write_address, MEM_write_data, e.len, e.addr, e.data);
                end
            end
        end
    end

    // Enqueue one store, retrying while the buffer is full; the expected write is pushed on acceptance.
    task automatic do_store(input logic [1:0] len, input logic [31:0] addr, input logic [31:0] data);
        int unsigned tries = 0;
        LSU_store_valid   = 1'b1;
        LSU_store_length  = len;
        LSU_store_address = addr;
        LSU_store_data    = data;
        forever begin
            @(negedge SYS_clk);
            if (LSU_store_ready) begin
                exp_q.push_back('{len: len, addr: addr, data: data});
                @(posedge SYS_clk); #1;
                break;
            end
            @(posedge SYS_clk); #1;
            tries++;
            if (tries > 20) begin
                total++; bad++;
                $display("FAIL store_accept_timeout: got ready=0 for 20 cycles, required acceptance");
                break;
            end
        end
        LSU_store_valid = 1'b0;
    endtask

    // Present one load for a cycle and check the result at the falling edge.
    task automatic do_load(input string nm, input logic [1:0] len, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_stall);
        LSU_load_valid   = 1'b1;
        LSU_load_length  = len;
        LSU_load_signed  = sgn;
        LSU_load_address = addr;
        @(negedge SYS_clk);
        total++;
        if (LSU_load_stall !== exp_stall) begin
            bad++;
            $display("FAIL %s_stall: got %b, required %b", nm, LSU_load_stall, exp_stall);
        end
        total++;
        if (LSU_load_data !== exp_data) begin
            bad++;
            $display("FAIL %s_data: got %h, required %h", nm, LSU_load_data, exp_data);
        end
        total++;
        if (MEM_read_address !== addr) begin
            bad++;
            $display("FAIL %s_rd_addr: got %h, required %h", nm, MEM_read_address, addr);
        end
        @(posedge SYS_clk); #1;
        LSU_load_valid = 1'b0;
    endtask

    task automatic drain_all(input string nm);
        int unsigned n = 0;
        SB_drain_hold = 1'b0;
        @(negedge SYS_clk);
        while (!SB_empty && n < 30) begin
            @(negedge SYS_clk);
            n++;
        end
        total++;
        if (SB_empty !== 1'b1) begin
            bad++;
            $display("FAIL %s_drain: got count=%0d, required empty", nm, SB_count);
        end
        @(posedge SYS_clk); #1;
    endtask

    task automatic test_reset;
        SYS_reset_n = 1'b0;
        LSU_store_valid = 1'b0; LSU_store_length = 2'b00;
        LSU_store_address = '0; LSU_store_data = '0;
        LSU_load_valid = 1'b0; LSU_load_length = 2'b00;
        LSU_load_signed = 1'b0; LSU_load_address = '0;
        SB_drain_hold = 1'b0;
        #1;
        total++;
        if ({SB_empty, LSU_store_ready, MEM_write_length, SB_count, LSU_load_stall} !== {1'b1, 1'b1, 2'b00, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_in: got empty=%b ready=%b wlen=%0d count=%0d stall=%b, required 1 1 0 0 0",
                     SB_empty, LSU_store_ready, MEM_write_length, SB_count, LSU_load_stall);
        end
        repeat (2) @(posedge SYS_clk);
        #1 SYS_reset_n = 1'b1;
        @(negedge SYS_clk);
        total++;
        if ({SB_empty, LSU_store_ready, MEM_write_length} !== {1'b1, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL reset_idle: got empty=%b ready=%b wlen=%0d, required 1 1 0",
                     SB_empty, LSU_store_ready, MEM_write_length);
        end
        @(posedge SYS_clk); #1;
    endtask

    task automatic test_fill_drain;
        SB_drain_hold = 1'b1;
        do_store(2'b11, 32'h100, 32'h11223344);
        do_store(2'b01, 32'h104, 32'h000000AA);
        do_store(2'b10, 32'h106, 32'h0000BEEF);
        do_store(2'b11, 32'h108, 32'h55667788);
        @(negedge SYS_clk);
        total++;
        if (SB_count !== 3'd4 || LSU_store_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: got count=%0d ready=%b, required 4 0", SB_count, LSU_store_ready);
        end
        // A fifth store must not be taken while full.
        @(posedge SYS_clk); #1;
        LSU_store_valid = 1'b1; LSU_store_length = 2'b11;
        LSU_store_address = 32'h10C; LSU_store_data = 32'hDEADDEAD;
        @(posedge SYS_clk); #1;
        LSU_store_valid = 1'b0;
        @(negedge SYS_clk);
        total++;
        if (SB_count !== 3'd4) begin
            bad++;
            $display("FAIL fill_fifth: got count=%0d, required 4", SB_count);
        end
        @(posedge SYS_clk); #1;
        SB_drain_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge SYS_clk);
            total++;
            if (MEM_write_length === 2'b00) begin
                bad++;
                $display("FAIL drain_cycle%0d: got wlen=0, required a write", i);
            end
        end
        @(negedge SYS_clk);
        total++;
        if (SB_empty !== 1'b1 || MEM_write_length !== 2'b00) begin
            bad++;
            $display("FAIL drain_empty: got empty=%b wlen=%0d, required 1 0", SB_empty, MEM_write_length);
        end
        @(posedge SYS_clk); #1;
    endtask

    task automatic test_forward;
        SB_drain_hold = 1'b1;
        do_store(2'b11, 32'h200, 32'h8000FF80);
        do_load("fwd_sbyte", 2'b01, 1'b1, 32'h200, 32'hFFFFFF80, 1'b0);
        do_load("fwd_uhalf", 2'b10, 1'b0, 32'h200, 32'h0000FF80, 1'b0);
        do_load("fwd_sword", 2'b11, 1'b1, 32'h200, 32'h8000FF80, 1'b0);
        do_load("fwd_offset", 2'b01, 1'b0, 32'h201, 32'h00000000, 1'b1);
        do_load("fwd_adjacent", 2'b11, 1'b0, 32'h204, mem_rd(32'h204), 1'b0);
        do_load("fwd_below", 2'b11, 1'b0, 32'h1FC, mem_rd(32'h1FC), 1'b0);
        drain_all("fwd");
    endtask

    task automatic test_partial;
        SB_drain_hold = 1'b1;
        do_store(2'b01, 32'h301, 32'h00000012);
        LSU_load_valid = 1'b1; LSU_load_length = 2'b11;
        LSU_load_signed = 1'b0; LSU_load_address = 32'h300;
        @(negedge SYS_clk);
        total++;
        if (LSU_load_stall !== 1'b1 || LSU_load_data !== 32'h0) begin
            bad++;
            $display("FAIL partial_held: got stall=%b data=%h, required 1 00000000", LSU_load_stall, LSU_load_data);
        end
        @(posedge SYS_clk); #1;
        SB_drain_hold = 1'b0;
        @(negedge SYS_clk);
        total++;
        if (LSU_load_stall !== 1'b1) begin
            bad++;
            $display("FAIL partial_draining: got stall=%b, required 1", LSU_load_stall);
        end
        @(negedge SYS_clk);
        total++;
        if (LSU_load_stall !== 1'b0 || LSU_load_data !== mem_rd(32'h300)) begin
            bad++;
            $display("FAIL partial_after: got stall=%b data=%h, required 0 %h",
                     LSU_load_stall, LSU_load_data, mem_rd(32'h300));
        end
        @(posedge SYS_clk); #1;
        LSU_load_valid = 1'b0;
    endtask

    task automatic test_youngest;
        SB_drain_hold = 1'b1;
        do_store(2'b11, 32'h400, 32'h00000001);
        do_store(2'b11, 32'h400, 32'h00000002);
        do_load("young_word", 2'b11, 1'b0, 32'h400, 32'h00000002, 1'b0);
        drain_all("young_a");
        SB_drain_hold = 1'b1;
        do_store(2'b11, 32'h400, 32'h00000033);
        do_store(2'b01, 32'h402, 32'h00000044);
        do_load("young_partial", 2'b11, 1'b0, 32'h400, 32'h00000000, 1'b1);
        do_load("young_older_cov", 2'b01, 1'b0, 32'h400, 32'h00000033, 1'b0);
        drain_all("young_b");
    endtask

    task automatic test_wrap;
        logic [1:0] lens[3] = '{2'b11, 2'b01, 2'b10};
        for (int i = 0; i < 10; i++) begin
            SB_drain_hold = i[0];
            do_store(lens[i % 3], 32'h500 + 32'(4 * i), $urandom);
            @(negedge SYS_clk);
            total++;
            if (SB_count > 3'(DEPTH)) begin
                bad++;
                $display("FAIL wrap_count%0d: got %0d, required <= %0d", i, SB_count, DEPTH);
            end
            @(posedge SYS_clk); #1;
        end
        drain_all("wrap");
    endtask

    task automatic test_reset_mid_drain;
        SB_drain_hold = 1'b1;
        do_store(2'b11, 32'h600, 32'hA0A0A0A0);
        do_store(2'b11, 32'h604, 32'hB0B0B0B0);
        do_store(2'b11, 32'h608, 32'hC0C0C0C0);
        @(negedge SYS_clk);
        total++;
        if (SB_count !== 3'd3) begin
            bad++;
            $display("FAIL rst_pre_count: got %0d, required 3", SB_count);
        end
        @(posedge SYS_clk); #1;
        SB_drain_hold = 1'b0;
        #2 SYS_reset_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if (SB_count !== 3'd0 || MEM_write_length !== 2'b00 || SB_empty !== 1'b1 || LSU_store_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_async: got count=%0d wlen=%0d empty=%b ready=%b, required 0 0 1 1",
                     SB_count, MEM_write_length, SB_empty, LSU_store_ready);
        end
        @(posedge SYS_clk); #1;
        SYS_reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge SYS_clk);
            total++;
            if (MEM_write_length !== 2'b00 || SB_count !== 3'd0) begin
                bad++;
                $display("FAIL rst_after%0d: got wlen=%0d count=%0d, required 0 0", i, MEM_write_length, SB_count);
            end
        end
        @(posedge SYS_clk); #1;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_forward();
        test_partial();
        test_youngest();
        test_wrap();
        test_reset_mid_drain();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: got %0d pending writes, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1, "timeout");
    end

endmodule
